layer_sched: RTL and testbench
==============================

LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 The block SHALL have parameter NUM_LAYERS, default 3: number of layers sequenced per run, minimum 1.
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 8: cycles waited after iterator ready for the conv/acc/relu/pool pipeline to flush, minimum 1.
REQ-003 The block SHALL have parameter TIMEOUT, default 65535: watchdog limit in cycles, used only with the macro in REQ-023.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all logic rising-edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: begins a run when sampled high in IDLE.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous cancel.
REQ-008 The block SHALL have port iter_ready, input, 1 bit: end-of-sweep pulse from the address iterator.
REQ-009 The block SHALL have port out_en, input, 1 bit: result-valid strobe from the last pipeline stage.
REQ-010 The block SHALL have port iter_go, output, 1 bit: single-cycle launch pulse to the iterator.
REQ-011 The block SHALL have port layer_idx, output, $clog2(NUM_LAYERS)+1 bits: index of the active layer.
REQ-012 The block SHALL have the following 1-bit outputs: busy, high in any state except IDLE; layer_done, per-layer completion pulse; all_done, end-of-run pulse.
REQ-013 The block SHALL have port out_cnt, output, 16 bits: out_en count for the current layer.
REQ-014 The block SHALL have port err, output, 1 bit: sticky watchdog error, present only with the macro in REQ-023.

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH, RUN and DRAIN, and all outputs SHALL be registered or decoded from the state register with no input-to-output combinational path.
REQ-016 With start high in IDLE at cycle t, the FSM SHALL be in LAUNCH at t+1, iter_go SHALL be high for exactly that cycle, and the FSM SHALL be in RUN at t+2.
REQ-017 In RUN, iter_ready SHALL move the FSM to DRAIN, and iter_ready SHALL be ignored in every other state.
REQ-018 DRAIN SHALL last exactly DRAIN_CYCLES cycles, with layer_done high only in the last DRAIN cycle; if layer_idx is below NUM_LAYERS-1, layer_idx SHALL then increment and the FSM SHALL go to LAUNCH; otherwise all_done SHALL pulse in the same cycle as layer_done, and the FSM SHALL go to IDLE with layer_idx set to 0.
REQ-019 start SHALL be ignored in any state other than IDLE.
REQ-020 out_cnt SHALL clear in LAUNCH, increment on out_en in RUN and DRAIN, hold in IDLE, and saturate at 16'hFFFF.
REQ-021 abort SHALL take priority over every other input: from any state the FSM SHALL be in IDLE on the next cycle with layer_idx set to 0, and no iter_go, layer_done or all_done SHALL be issued in that transition; if start and abort are high together in IDLE, the FSM SHALL stay in IDLE.

Reset
REQ-022 While rstn is low, the FSM SHALL be in IDLE with iter_go, layer_idx, busy, layer_done, all_done, out_cnt and err all at 0; reset mid-run SHALL drop the run and SHALL issue no pulses after release.

Configuration
REQ-023 With LAYER_SCHED_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in RUN; on reaching TIMEOUT without iter_ready it SHALL set err, and the FSM SHALL go to IDLE with layer_idx set to 0.
REQ-024 err SHALL then stay set until the next accepted start or reset.
REQ-025 Without LAYER_SCHED_TIMEOUT_EN, the err port and the watchdog SHALL not exist, and RUN SHALL wait indefinitely.

Verification
REQ-026 Scenario, nominal run: NUM_LAYERS=3, DRAIN_CYCLES=8, start at cycle 10, iter_ready 20 cycles after each iter_go -> iter_go at cycles 11, 40 and 69; layer_done at 39, 68 and 97; all_done at 97; busy low from 98.
REQ-027 Scenario, abort: abort in the 3rd DRAIN cycle of layer 1 -> IDLE next cycle, layer_idx=0, no layer_done; a new start then launches layer 0.
REQ-028 Scenario, start filtering: start pulsed during RUN -> ignored; start and abort together in IDLE -> busy stays 0 and no iter_go.
REQ-029 Scenario, out_cnt: 5 out_en pulses in layer 0 -> out_cnt=5 at layer_done, 0 in the next LAUNCH cycle; 70000 pulses -> out_cnt=65535.
REQ-030 Scenario, watchdog: with the macro, TIMEOUT=100 and iter_ready withheld -> err set 100 cycles after RUN entry and FSM in IDLE; without the macro -> FSM stays in RUN.
REQ-031 Scenario, reset mid-run: rstn low during RUN of layer 2 -> all outputs 0 asynchronously, and no pulses after release until a new start.

Source files
------------

// File: rtl/layer_sched_if.sv
// Handshake/status bundle between layer_sched and its controller, iterator and pipeline.
// The err signal exists only when LAYER_SCHED_TIMEOUT_EN is defined.
interface layer_sched_if #(
    parameter int NUM_LAYERS = 3
);
    localparam int IDX_W = $clog2(NUM_LAYERS) + 1;

    logic             start;
    logic             abort;
    logic             iter_ready;
    logic             out_en;
    logic             iter_go;
    logic [IDX_W-1:0] layer_idx;
    logic             busy;
    logic             layer_done;
    logic             all_done;
    logic [15:0]      out_cnt;
`ifdef LAYER_SCHED_TIMEOUT_EN
    logic             err;

    modport master (
        input  start, abort, iter_ready, out_en,
        output iter_go, layer_idx, busy, layer_done, all_done, out_cnt, err
    );

    modport slave (
        output start, abort, iter_ready, out_en,
        input  iter_go, layer_idx, busy, layer_done, all_done, out_cnt, err
    );
`else
    modport master (
        input  start, abort, iter_ready, out_en,
        output iter_go, layer_idx, busy, layer_done, all_done, out_cnt
    );

    modport slave (
        output start, abort, iter_ready, out_en,
        input  iter_go, layer_idx, busy, layer_done, all_done, out_cnt
    );
`endif
endinterface

// File: rtl/layer_sched.sv
// Layer sequencer: launches the address iterator once per layer, waits for the pipeline
// to drain, then advances. Optional RUN watchdog enabled by defining LAYER_SCHED_TIMEOUT_EN.
module layer_sched #(
    parameter int NUM_LAYERS   = 3,
    parameter int DRAIN_CYCLES = 8,
    parameter int TIMEOUT      = 65535
) (
    input  logic          clk,
    input  logic          rstn,
    layer_sched_if.master bus
);
    localparam int             LW         = $clog2(NUM_LAYERS) + 1;
    localparam int             DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [LW-1:0]  LAST_LAYER = LW'(NUM_LAYERS - 1);
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    if (NUM_LAYERS < 1 || DRAIN_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("layer_sched: NUM_LAYERS, DRAIN_CYCLES and TIMEOUT must all be at least 1");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DRAIN} state_t;

    state_t          state, state_nx;
    logic [LW-1:0]   layer_idx_q, layer_idx_nx;
    logic [DW-1:0]   drain_cnt, drain_cnt_nx;
    logic [15:0]     out_cnt_q, out_cnt_nx;
    logic            last_drain;
    logic            counting;

`ifdef LAYER_SCHED_TIMEOUT_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);
    logic [31:0]     wd_cnt, wd_cnt_nx;
    logic            err_q, err_nx;
`endif

    assign last_drain = (state == DRAIN) && (drain_cnt == DRAIN_LAST);
    assign counting   = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            layer_idx_q <= '0;
            drain_cnt   <= '0;
            out_cnt_q   <= '0;
`ifdef LAYER_SCHED_TIMEOUT_EN
            wd_cnt      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            layer_idx_q <= layer_idx_nx;
            drain_cnt   <= drain_cnt_nx;
            out_cnt_q   <= out_cnt_nx;
`ifdef LAYER_SCHED_TIMEOUT_EN
            wd_cnt      <= wd_cnt_nx;
            err_q       <= err_nx;
`endif
        end
    end

    // Abort overrides everything and leaves out_cnt holding its last value for inspection.
    always_comb begin
        state_nx     = state;
        layer_idx_nx = layer_idx_q;
        drain_cnt_nx = drain_cnt;
        out_cnt_nx   = out_cnt_q;
`ifdef LAYER_SCHED_TIMEOUT_EN
        wd_cnt_nx    = wd_cnt;
        err_nx       = err_q;
`endif
        if (counting && bus.out_en && (out_cnt_q != 16'hFFFF)) begin
            out_cnt_nx = out_cnt_q + 16'd1;
        end

        if (bus.abort) begin
            state_nx     = IDLE;
            layer_idx_nx = '0;
            drain_cnt_nx = '0;
            out_cnt_nx   = out_cnt_q;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nx   = LAUNCH;
                        out_cnt_nx = '0;
`ifdef LAYER_SCHED_TIMEOUT_EN
                        err_nx     = 1'b0;
`endif
                    end
                end
                LAUNCH: begin
                    state_nx = RUN;
`ifdef LAYER_SCHED_TIMEOUT_EN
                    wd_cnt_nx = '0;
`endif
                end
                RUN: begin
                    if (bus.iter_ready) begin
                        state_nx     = DRAIN;
                        drain_cnt_nx = '0;
                    end
`ifdef LAYER_SCHED_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        state_nx     = IDLE;
                        layer_idx_nx = '0;
                        err_nx       = 1'b1;
                    end else begin
                        wd_cnt_nx = wd_cnt + 32'd1;
                    end
`endif
                end
                DRAIN: begin
                    if (last_drain) begin
                        drain_cnt_nx = '0;
                        if (layer_idx_q == LAST_LAYER) begin
                            state_nx     = IDLE;
                            layer_idx_nx = '0;
                        end else begin
                            state_nx     = LAUNCH;
                            layer_idx_nx = layer_idx_q + LW'(1);
                            out_cnt_nx   = '0;
                        end
                    end else begin
                        drain_cnt_nx = drain_cnt + DW'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Every output is decoded from registered state so no input reaches an output directly.
    assign bus.iter_go    = (state == LAUNCH);
    assign bus.busy       = (state != IDLE);
    assign bus.layer_done = last_drain;
    assign bus.all_done   = last_drain && (layer_idx_q == LAST_LAYER);
    assign bus.layer_idx  = layer_idx_q;
    assign bus.out_cnt    = out_cnt_q;
`ifdef LAYER_SCHED_TIMEOUT_EN
    assign bus.err        = err_q;
`endif

endmodule

// File: tb/tb_layer_sched.sv
// Scoreboard bench for layer_sched: expected iter_go/layer_done events are queued when a run
// is started and checked as the pulses appear. Covers the watchdog when LAYER_SCHED_TIMEOUT_EN is set.
module tb_layer_sched;
    localparam int NL = 3;
    localparam int DC = 8;
    localparam int TO = 100;

    typedef struct {
        int at;
        int idx;
        int cnt;
        int all;
    } ev_t;

    logic clk;
    logic rstn;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    int   ready_delay;
    int   en_pulses[8];
    ev_t  go_q[$];
    ev_t  done_q[$];
    ev_t  mon_ev;
    int   c0;

    layer_sched_if #(.NUM_LAYERS(NL)) bus ();

    layer_sched #(
        .NUM_LAYERS  (NL),
        .DRAIN_CYCLES(DC),
        .TIMEOUT     (TO)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic stepTo(input int c);
        while (cyc < c) step(1);
    endtask

    // Drive start/abort during the current cycle; returns inside the following cycle.
    task automatic applyStimulus(input logic s, input logic a);
        bus.start = s;
        bus.abort = a;
        step(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    // Expected schedule of a run started in cycle c with iter_ready 'delay' cycles after iter_go.
    task automatic pushRun(input int c, input int n_go, input int n_done, input int delay);
        int go_at;
        for (int l = 0; l < n_go; l++) begin
            go_at = c + 1 + l * (delay + DC + 1);
            go_q.push_back('{go_at, l, 0, 0});
            if (l < n_done)
                done_q.push_back('{go_at + delay + DC, l, en_pulses[l], (l == NL - 1) ? 1 : 0});
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " busy"}, int'(bus.busy), 0);
        checkOutput({tag, " iter_go"}, int'(bus.iter_go), 0);
        checkOutput({tag, " layer_idx"}, int'(bus.layer_idx), 0);
        checkOutput({tag, " out_cnt"}, int'(bus.out_cnt), 0);
        checkOutput({tag, " layer_done"}, int'(bus.layer_done), 0);
        checkOutput({tag, " all_done"}, int'(bus.all_done), 0);
`ifdef LAYER_SCHED_TIMEOUT_EN
        checkOutput({tag, " err"}, int'(bus.err), 0);
`endif
    endtask

    // Pulse monitor: every launch and completion must match the head of its queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                if (bus.iter_go === 1'b1) begin
                    if (go_q.size() == 0) begin
                        checkOutput("iter_go unexpected", 1, 0);
                    end else begin
                        mon_ev = go_q.pop_front();
                        checkOutput("iter_go cycle", cyc, mon_ev.at);
                        checkOutput("iter_go layer_idx", int'(bus.layer_idx), mon_ev.idx);
                        checkOutput("out_cnt at launch", int'(bus.out_cnt), 0);
                    end
                end
                if (bus.layer_done === 1'b1) begin
                    if (done_q.size() == 0) begin
                        checkOutput("layer_done unexpected", 1, 0);
                    end else begin
                        mon_ev = done_q.pop_front();
                        checkOutput("layer_done cycle", cyc, mon_ev.at);
                        checkOutput("layer_done layer_idx", int'(bus.layer_idx), mon_ev.idx);
                        checkOutput("out_cnt at layer_done", int'(bus.out_cnt), mon_ev.cnt);
                        checkOutput("all_done", int'(bus.all_done), mon_ev.all);
                    end
                end else if (bus.all_done === 1'b1) begin
                    checkOutput("all_done without layer_done", 1, 0);
                end
            end
        end
    end

    // Iterator/pipeline model: after each iter_go emit out_en pulses, then iter_ready.
    initial begin
        int n;
        forever begin
            @(negedge clk);
            if (bus.iter_go === 1'b1 && ready_delay > 0) begin
                n = en_pulses[int'(bus.layer_idx)];
                for (int k = 1; k <= ready_delay; k++) begin
                    @(posedge clk);
                    #2;
                    bus.out_en = (k <= n) ? 1'b1 : 1'b0;
                    if (k == ready_delay) bus.iter_ready = 1'b1;
                end
                @(posedge clk);
                #2;
                bus.iter_ready = 1'b0;
                bus.out_en     = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global timeout: got still running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        rstn           = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.iter_ready = 1'b0;
        bus.out_en     = 1'b0;
        ready_delay    = 20;
        for (int i = 0; i < 8; i++) en_pulses[i] = 0;
        en_pulses[0] = 5;
        en_pulses[2] = 3;

        step(2);
        checkIdleOutputs("reset");
        rstn = 1'b1;

        // Nominal three-layer run started in cycle 10.
        stepTo(10);
        pushRun(10, 3, 3, 20);
        applyStimulus(1'b1, 1'b0);
        stepTo(50);
        applyStimulus(1'b1, 1'b0);
        stepTo(97);
        checkOutput("busy in last drain", int'(bus.busy), 1);
        step(1);
        checkOutput("busy after run", int'(bus.busy), 0);
        checkOutput("layer_idx after run", int'(bus.layer_idx), 0);

        // Abort in the third DRAIN cycle of layer 1, then relaunch layer 0.
        stepTo(105);
        c0 = cyc;
        pushRun(c0, 2, 1, 20);
        applyStimulus(1'b1, 1'b0);
        stepTo(c0 + 53);
        checkOutput("busy before abort", int'(bus.busy), 1);
        checkOutput("layer_idx before abort", int'(bus.layer_idx), 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("busy after abort", int'(bus.busy), 0);
        checkOutput("layer_idx after abort", int'(bus.layer_idx), 0);
        stepTo(c0 + 56);
        go_q.push_back('{c0 + 57, 0, 0, 0});
        applyStimulus(1'b1, 1'b0);
        checkOutput("relaunch layer_idx", int'(bus.layer_idx), 0);
        step(1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("busy after second abort", int'(bus.busy), 0);
        stepTo(c0 + 90);
        checkOutput("busy with stray iter_ready", int'(bus.busy), 0);

        // start and abort together in IDLE.
        applyStimulus(1'b1, 1'b1);
        checkOutput("start+abort busy", int'(bus.busy), 0);
        checkOutput("start+abort iter_go", int'(bus.iter_go), 0);
        step(2);
        checkOutput("start+abort busy later", int'(bus.busy), 0);

        // Reset during RUN of layer 2.
        c0 = cyc;
        pushRun(c0, 3, 2, 20);
        applyStimulus(1'b1, 1'b0);
        stepTo(c0 + 65);
        checkOutput("layer_idx before reset", int'(bus.layer_idx), 2);
        rstn = 1'b0;
        #1;
        checkIdleOutputs("mid-run reset");
        step(2);
        rstn = 1'b1;
        step(40);
        checkOutput("busy after reset release", int'(bus.busy), 0);

`ifdef LAYER_SCHED_TIMEOUT_EN
        // Watchdog: RUN entered in cycle c0+2, err expected 100 cycles later.
        ready_delay = 0;
        c0 = cyc;
        go_q.push_back('{c0 + 1, 0, 0, 0});
        applyStimulus(1'b1, 1'b0);
        stepTo(c0 + 101);
        checkOutput("wd err before limit", int'(bus.err), 0);
        checkOutput("wd busy before limit", int'(bus.busy), 1);
        step(1);
        checkOutput("wd err at limit", int'(bus.err), 1);
        checkOutput("wd busy at limit", int'(bus.busy), 0);
        checkOutput("wd layer_idx at limit", int'(bus.layer_idx), 0);
        step(5);
        checkOutput("wd err sticky", int'(bus.err), 1);
        c0 = cyc;
        go_q.push_back('{c0 + 1, 0, 0, 0});
        applyStimulus(1'b1, 1'b0);
        checkOutput("wd err cleared by start", int'(bus.err), 0);
        applyStimulus(1'b0, 1'b1);
`else
        // out_cnt saturation with iter_ready withheld; RUN must wait indefinitely.
        ready_delay = 0;
        c0 = cyc;
        go_q.push_back('{c0 + 1, 0, 0, 0});
        applyStimulus(1'b1, 1'b0);
        step(1);
        bus.out_en = 1'b1;
        step(65534);
        checkOutput("out_cnt near saturation", int'(bus.out_cnt), 65534);
        step(5000);
        checkOutput("out_cnt saturated", int'(bus.out_cnt), 65535);
        bus.out_en = 1'b0;
        checkOutput("still in RUN without iter_ready", int'(bus.busy), 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("busy after sat abort", int'(bus.busy), 0);
        checkOutput("out_cnt held in IDLE", int'(bus.out_cnt), 65535);
        c0 = cyc;
        go_q.push_back('{c0 + 1, 0, 0, 0});
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
`endif

        step(5);
        checkOutput("iter_go events outstanding", go_q.size(), 0);
        checkOutput("layer_done events outstanding", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
